// File: rtl/ula_pkg.sv
// Shared ULA definitions: operand width, multiplier FSM encoding and iteration counter width.
package ula_pkg;

    localparam int ULA_W = 8;
    localparam int CNT_W = $clog2(ULA_W);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_CALC = 1'b1
    } mult_state_t;

endpackage

// File: rtl/somador2w.sv
// N-bit ripple-carry adder built from full-adder cells; the carry out of the top bit is dropped.
module somador2w #(
    parameter int N = 16
) (
    input  logic [N-1:0] i_a,
    input  logic [N-1:0] i_b,
    output logic [N-1:0] o_sum
);

    logic [N-1:0] w_carry;

    assign w_carry[0] = 1'b0;

    genvar i;
    generate
        for (i = 0; i < N; i++) begin : g_fa
            assign o_sum[i] = i_a[i] ^ i_b[i] ^ w_carry[i];
            // The top cell has no consumer for its carry, so the chain stops one short.
            if (i < N - 1) begin : g_carry
                assign w_carry[i+1] = (i_a[i] & i_b[i]) | (w_carry[i] & (i_a[i] ^ i_b[i]));
            end
        end
    endgenerate

endmodule

// File: rtl/multiplicador_seq.sv
// Sequential shift-and-add unsigned multiplier, one multiplier bit per clock.
// Optional MULT_ZERO_SKIP_EN: finish early once the remaining multiplier bits are all zero.
module multiplicador_seq
    import ula_pkg::*;
#(
    parameter int W = ULA_W
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic [W-1:0]   A,
    input  logic [W-1:0]   B,
    output logic           busy,
    output logic           done,
    output logic [2*W-1:0] P,
    output logic [W-1:0]   S,
    output logic           OVF,
    output logic           ZERO
);

    mult_state_t    r_state;
    mult_state_t    w_nextState;
    logic [2*W-1:0] r_acc;
    logic [2*W-1:0] r_mcand;
    logic [W-1:0]   r_mult;
    logic [CNT_W-1:0] r_cnt;
    logic [2*W-1:0] r_P;
    logic           r_OVF;
    logic           r_done;

    logic [2*W-1:0] w_addend;
    logic [2*W-1:0] w_sum;
    logic [W-1:0]   w_multShift;
    logic           w_last;
    logic           w_load;
    logic           w_finish;

    assign w_addend    = r_mult[0] ? r_mcand : '0;
    assign w_multShift = r_mult >> 1;

    somador2w #(
        .N(2*W)
    ) u_somador (
        .i_a  (r_acc),
        .i_b  (w_addend),
        .o_sum(w_sum)
    );

`ifdef MULT_ZERO_SKIP_EN
    assign w_last = (r_cnt == CNT_W'(W - 1)) || (w_multShift == '0);
`else
    assign w_last = (r_cnt == CNT_W'(W - 1));
`endif

    always_comb begin
        w_nextState = r_state;
        w_load      = 1'b0;
        w_finish    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_nextState = ST_CALC;
                    w_load      = 1'b1;
                end
            end
            ST_CALC: begin
                if (w_last) begin
                    w_nextState = ST_IDLE;
                    w_finish    = 1'b1;
                end
            end
        endcase
    end

    // The final partial sum goes straight to P so done can follow on the very next cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_acc   <= '0;
            r_mcand <= '0;
            r_mult  <= '0;
            r_cnt   <= '0;
            r_P     <= '0;
            r_OVF   <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_nextState;
            r_done  <= w_finish;
            if (w_load) begin
                r_mcand <= {{W{1'b0}}, A};
                r_mult  <= B;
                r_acc   <= '0;
                r_cnt   <= '0;
            end else if (r_state == ST_CALC) begin
                r_acc   <= w_sum;
                r_mcand <= r_mcand << 1;
                r_mult  <= w_multShift;
                r_cnt   <= r_cnt + CNT_W'(1);
            end
            if (w_finish) begin
                r_P   <= w_sum;
                r_OVF <= |w_sum[2*W-1:W];
            end
        end
    end

    assign busy = (r_state == ST_CALC);
    assign done = r_done;
    assign P    = r_P;
    assign S    = r_P[W-1:0];
    assign OVF  = r_OVF;
    assign ZERO = (r_P == '0);

endmodule
